// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: stall/halt inputs and phase/status outputs of the phase sequencer
interface phase_sequencer_if #(parameter int XLEN = 32);
  logic            stall_fetch;
  logic            stall_execute;
  logic            stall_memoryaccess;
  logic            halt_req;
  logic            phase_fetch;
  logic            phase_decode;
  logic            phase_execute;
  logic            phase_memoryaccess;
  logic            phase_writeback;
  logic            halted;
  logic            stall_timeout;
  logic [XLEN-1:0] instret;
  modport master (
    input  stall_fetch, stall_execute, stall_memoryaccess, halt_req,
    output phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback,
    output halted, stall_timeout, instret
  );
  modport slave (
    output stall_fetch, stall_execute, stall_memoryaccess, halt_req,
    input  phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback,
    input  halted, stall_timeout, instret
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: five-phase one-hot instruction cycle with stall hold, halt parking, retire count and stall watchdog
module phase_sequencer #(
  parameter int XLEN          = 32,
  parameter int STALL_TIMEOUT = 16,
  parameter int TMO_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  phase_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMACC, WRITEBACK, HALT} state_t;
  localparam bit               WD_EN   = STALL_TIMEOUT != 0;
  localparam logic [TMO_W-1:0] TRIP_AT = TMO_W'(STALL_TIMEOUT - 1);
  state_t           r_state, w_next;
  logic [TMO_W-1:0] r_cnt;
  logic             r_tmo;
  logic [XLEN-1:0]  r_instret;
  logic             w_stall, w_trip;
  always_comb begin
    w_stall = (r_state == FETCH   && bus.stall_fetch)
           || (r_state == EXECUTE && bus.stall_execute)
           || (r_state == MEMACC  && bus.stall_memoryaccess);
    // trips on the edge that would make the STALL_TIMEOUT-th consecutive stalled cycle
    w_trip = WD_EN && w_stall && r_cnt == TRIP_AT;
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = FETCH;
      FETCH:     w_next = w_stall ? FETCH : DECODE;
      DECODE:    w_next = EXECUTE;
      EXECUTE:   w_next = w_stall ? EXECUTE : MEMACC;
      MEMACC:    w_next = w_stall ? MEMACC : WRITEBACK;
      WRITEBACK: w_next = bus.halt_req ? HALT : FETCH;
      HALT:      w_next = (!bus.halt_req && !r_tmo) ? FETCH : HALT;
      default:   w_next = IDLE;
    endcase
    if (w_trip) w_next = HALT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_stall && !w_trip) ? r_cnt + 1'b1 : '0;
      r_tmo     <= r_tmo | w_trip;
      r_instret <= (r_state == WRITEBACK) ? r_instret + 1'b1 : r_instret;
    end
  end
  assign bus.phase_fetch        = r_state == FETCH;
  assign bus.phase_decode       = r_state == DECODE;
  assign bus.phase_execute      = r_state == EXECUTE;
  assign bus.phase_memoryaccess = r_state == MEMACC;
  assign bus.phase_writeback    = r_state == WRITEBACK;
  assign bus.halted             = r_state == HALT;
  assign bus.stall_timeout      = r_tmo;
  assign bus.instret            = r_instret;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed checks of phase order, stalls, halt, watchdog, reset and instret wrap
module tb_phase_sequencer;
  localparam logic [4:0] F = 5'b10000, D = 5'b01000, E = 5'b00100, M = 5'b00010, W = 5'b00001, Z = 5'b00000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  phase_sequencer_if #(.XLEN(32)) bus ();
  phase_sequencer_if #(.XLEN(4))  bus4 ();
  phase_sequencer #(.XLEN(32), .STALL_TIMEOUT(16), .TMO_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  phase_sequencer #(.XLEN(4), .STALL_TIMEOUT(16), .TMO_W(8)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));
  always #5 clk = ~clk;
  function automatic logic [4:0] ph();
    return {bus.phase_fetch, bus.phase_decode, bus.phase_execute, bus.phase_memoryaccess, bus.phase_writeback};
  endfunction
  function automatic logic [4:0] ph4();
    return {bus4.phase_fetch, bus4.phase_decode, bus4.phase_execute, bus4.phase_memoryaccess, bus4.phase_writeback};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.stall_fetch = 0; bus.stall_execute = 0; bus.stall_memoryaccess = 0; bus.halt_req = 0;
    bus4.stall_fetch = 0; bus4.stall_execute = 0; bus4.stall_memoryaccess = 0; bus4.halt_req = 0;
    tick(2);
    chk("rst_phase", ph(), Z);
    chk("rst_halted", bus.halted, 0);
    chk("rst_tmo", bus.stall_timeout, 0);
    chk("rst_instret", bus.instret, 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("seq_F", ph(), F); tick();
      chk("seq_D", ph(), D); tick();
      chk("seq_E", ph(), E); tick();
      chk("seq_M", ph(), M); tick();
      chk("seq_W", ph(), W); tick();
    end
    chk("seq_instret4", bus.instret, 4);
    // execute stall of 3 cycles; stall_fetch pulse in decode is ignored
    tick();
    chk("st2_D", ph(), D);
    bus.stall_fetch = 1;
    tick();
    bus.stall_fetch = 0;
    chk("st2_fetch_ignored", ph(), E);
    bus.stall_execute = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("st2_E_hold", ph(), E); end
    bus.stall_execute = 0;
    tick();
    chk("st2_M", ph(), M);
    chk("st2_tmo", bus.stall_timeout, 0);
    tick(2);
    chk("st2_F", ph(), F);
    chk("st2_instret5", bus.instret, 5);
    // halt requested in decode parks after writeback
    tick();
    bus.halt_req = 1;
    tick(3);
    chk("h3_W", ph(), W);
    tick();
    chk("h3_halted", bus.halted, 1);
    chk("h3_phase0", ph(), Z);
    chk("h3_instret6", bus.instret, 6);
    tick();
    chk("h3_still_halted", bus.halted, 1);
    bus.halt_req = 0;
    tick();
    chk("h3_resume_F", ph(), F);
    chk("h3_unhalted", bus.halted, 0);
    // 15 stalled edges then release: normal advance, no error
    bus.stall_fetch = 1;
    tick(15);
    chk("b_F_hold15", ph(), F);
    bus.stall_fetch = 0;
    tick();
    chk("b_D", ph(), D);
    chk("b_tmo", bus.stall_timeout, 0);
    // held memory stall trips watchdog on the 16th stalled edge
    tick(2);
    chk("wd_M", ph(), M);
    bus.stall_memoryaccess = 1;
    tick(15);
    chk("wd_M_hold15", ph(), M);
    chk("wd_no_tmo15", bus.stall_timeout, 0);
    tick();
    chk("wd_tmo", bus.stall_timeout, 1);
    chk("wd_halted", bus.halted, 1);
    chk("wd_phase0", ph(), Z);
    chk("wd_instret", bus.instret, 6);
    bus.stall_memoryaccess = 0;
    tick(3);
    chk("wd_sticky_halt", bus.halted, 1);
    chk("wd_sticky_tmo", bus.stall_timeout, 1);
    rst_n = 0;
    tick();
    chk("wd_rst_tmo", bus.stall_timeout, 0);
    chk("wd_rst_halted", bus.halted, 0);
    chk("wd_rst_instret", bus.instret, 0);
    rst_n = 1;
    tick();
    chk("wd_restart_F", ph(), F);
    // reset in the middle of MEMACC
    tick(5);
    chk("r5_instret1", bus.instret, 1);
    tick(3);
    chk("r5_M", ph(), M);
    rst_n = 0;
    tick();
    chk("r5_phase0", ph(), Z);
    chk("r5_instret0", bus.instret, 0);
    chk("r5_halted", bus.halted, 0);
    rst_n = 1;
    tick();
    chk("r5_restart_F", ph(), F);
    // 4-bit instret wraps after 16 instructions
    rst4_n = 1;
    tick();
    chk("w6_F", ph4(), F);
    tick(75);
    chk("w6_instret15", bus4.instret, 15);
    tick(5);
    chk("w6_wrap0", bus4.instret, 0);
    chk("w6_F_after", ph4(), F);
    chk("w6_halted", bus4.halted, 0);
    chk("w6_tmo", bus4.stall_timeout, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
